alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand and result width.
REQ-002 SHALL have parameter OP_W, default 3, opcode width.
REQ-003 SHALL have parameter CNT_W, default 16, completed-operation counter width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 2, per-requester request valid (bit i = requester i).
REQ-007 SHALL have port req_ready, output, 2, per-requester acceptance strobe.
REQ-008 SHALL have port req_op0 / req_op1, input, OP_W, opcode of requester 0 / 1.
REQ-009 SHALL have port req_a0, req_b0 / req_a1, req_b1, input, DATA_W, operands of requester 0 / 1.
REQ-010 SHALL have port rsp_valid, output, 1, result available.
REQ-011 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port rsp_data, output, DATA_W, registered ALU result.
REQ-013 SHALL have port rsp_id, output, 1, index of the requester that owns rsp_data.
REQ-014 SHALL have port rsp_err, output, 1, high when the executed opcode was 5..7.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-016 SHALL have port op_count, output, CNT_W, count of completed responses.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-018 In IDLE, req_ready[g] SHALL be 1 only for the granted requester g with req_valid[g]=1; all other req_ready bits SHALL be 0, and both bits SHALL be 0 outside IDLE.
REQ-019 Grant SHALL be round-robin: with both valid, grant goes to the requester that is not last_grant; with one valid, that one is granted.
REQ-020 On a handshake (req_valid[g] & req_ready[g]), the block SHALL latch opcode, a, b and g, SHALL set last_grant=g, and SHALL go to EXEC.
REQ-021 In EXEC, the block SHALL register the ALU output into rsp_data, set rsp_err = (opcode > 4), and go to RESP, for a fixed latency of 2 cycles from handshake to rsp_valid.
REQ-022 ALU semantics SHALL be: 0 a+b mod 2^DATA_W, 1 a-b mod 2^DATA_W (wrap on borrow), 2 a&b, 3 a|b, 4 ~a, 5..7 result 0.
REQ-023 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_id and rsp_err SHALL be held stable until rsp_ready=1.
REQ-024 On rsp_valid & rsp_ready, the block SHALL return to IDLE and increment op_count, which saturates at all-ones.
REQ-025 Requester inputs SHALL be ignored outside IDLE, and a request deasserted before a handshake SHALL be dropped without side effects.
REQ-026 Peak throughput SHALL be one operation per 3 cycles, and no new request SHALL be accepted in the cycle the response completes.

Reset
REQ-027 On rst_n=0, the block SHALL asynchronously set state=IDLE, last_grant=1 (so requester 0 wins first), rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, op_count=0, and latched operands to 0.
REQ-028 Reset asserted mid-operation SHALL abort it with no response and no count increment.
REQ-029 After release, the first grant SHALL occur no earlier than the first rising edge with rst_n=1.

Structure
REQ-030 A shared package alu_pkg SHALL hold opcode constants OP_PLUS=0, OP_MINUS=1, OP_AND=2, OP_OR=3, OP_NOT=4, together with the FSM state encoding.
REQ-031 The datapath SHALL be a single instance of the existing combinational alu sub-module, driven from the latched operands; the arbiter SHALL contain no duplicate arithmetic.

Verification
REQ-032 Req0 only: op=0, a=10, b=5 -> req_ready[0] in the accept cycle, rsp_valid 2 cycles later, rsp_data=15, rsp_id=0, rsp_err=0.
REQ-033 Both requesters valid after reset: req0 op=1 a=15 b=6, req1 op=2 a=0xAA b=0xCC -> req0 served first (9), then req1 (0x88, rsp_id=1).
REQ-034 Wrap: op=1, a=0, b=1 -> rsp_data=0xFF; op=0, a=0xFF, b=0x01 -> rsp_data=0x00.
REQ-035 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable, busy=1, req_ready=0 throughout; op_count increments once on release.
REQ-036 Illegal opcode 7 with a=0x0F -> rsp_data=0, rsp_err=1; op=4 with a=0x0F -> 0xF0, rsp_err=0.
REQ-037 rst_n pulsed low during EXEC -> rsp_valid stays 0, op_count unchanged (0), and requester 0 is granted first after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode values and FSM state encoding.
package alu_pkg;

    localparam int OP_PLUS  = 0;
    localparam int OP_MINUS = 1;
    localparam int OP_AND   = 2;
    localparam int OP_OR    = 3;
    localparam int OP_NOT   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by both requesters; opcodes above OP_NOT yield 0.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    // Opcode decode; add/sub wrap naturally at DATA_W bits
    always_comb begin
        y = '0;
        case (op)
            OP_W'(OP_PLUS):  y = a + b;
            OP_W'(OP_MINUS): y = a - b;
            OP_W'(OP_AND):   y = a & b;
            OP_W'(OP_OR):    y = a | b;
            OP_W'(OP_NOT):   y = ~a;
            default:         y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single ALU with a registered,
// back-pressurable response and a saturating completed-operation counter.
//
//   state | meaning
//   IDLE  | waiting for a request; req_ready offered to the granted requester
//   EXEC  | operands latched, ALU result being registered
//   RESP  | rsp_valid high, response held until rsp_ready
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [OP_W-1:0]   req_op1,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    state_t            state, state_nx;
    logic              last_grant;
    logic              grant;
    logic              hs;
    logic              id_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] alu_y;

    alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    // Round-robin pick: on contention the requester not served last wins
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
            grant = ~last_grant;
        end else if (req_valid[0]) begin
            grant = 1'b0;
        end else begin
            grant = 1'b1;
        end
    end

    // Acceptance strobe only in IDLE, only to the granted, valid requester
    always_comb begin
        req_ready = 2'b00;
        hs        = 1'b0;
        if (state == IDLE) begin
            req_ready[grant] = req_valid[grant];
            hs               = req_valid[grant];
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (hs) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request latch, result register and completion counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            if (hs) begin
                last_grant <= grant;
                id_q       <= grant;
                op_q       <= grant ? req_op1 : req_op0;
                a_q        <= grant ? req_a1 : req_a0;
                b_q        <= grant ? req_b1 : req_b0;
            end
            if (state == EXEC) begin
                rsp_data <= alu_y;
                rsp_id   <= id_q;
                rsp_err  <= (op_q > OP_W'(OP_NOT));
            end
            if (state == RESP && rsp_ready && op_count != {CNT_W{1'b1}}) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter.
module tb_alu_arbiter;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [OP_W-1:0]   req_op0, req_op1;
    logic [DATA_W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id;
    logic              rsp_err;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count = 0;

    alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_op1   (req_op1),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete transaction from a single requester, checking timing and result
    task automatic run_op(input logic id, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_data,
                          input logic exp_err, input string name);
        bit got;
        got = 0;
        if (id) begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end else begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end
        req_valid[id] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1;
                break;
            end
        end
        chk({name, " accepted"}, 32'(got), 32'd1);
        if (!got) begin
            req_valid = 2'b00;
            return;
        end
        chk({name, " ready onehot"}, 32'(req_ready), id ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        @(negedge clk);
        chk({name, " exec no valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
        chk({name, " rsp_id"}, 32'(rsp_id), 32'(id));
        chk({name, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_count++;
        chk({name, " op_count"}, 32'(op_count), 32'(exp_count));
        chk({name, " idle after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] hold_data;

        vecs[0] = '{3'd0, 8'd10,  8'd5,  8'd15,  1'b0};
        vecs[1] = '{3'd1, 8'd15,  8'd6,  8'd9,   1'b0};
        vecs[2] = '{3'd2, 8'hAA,  8'hCC, 8'h88,  1'b0};
        vecs[3] = '{3'd1, 8'h00,  8'h01, 8'hFF,  1'b0};
        vecs[4] = '{3'd0, 8'hFF,  8'h01, 8'h00,  1'b0};
        vecs[5] = '{3'd7, 8'h0F,  8'h00, 8'h00,  1'b1};
        vecs[6] = '{3'd4, 8'h0F,  8'h00, 8'hF0,  1'b0};
        vecs[7] = '{3'd3, 8'hA0,  8'h05, 8'hA5,  1'b0};
        vecs[8] = '{3'd5, 8'h12,  8'h34, 8'h00,  1'b1};
        vecs[9] = '{3'd6, 8'hFF,  8'hFF, 8'h00,  1'b1};

        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        req_op0 = '0; req_a0 = '0; req_b0 = '0;
        req_op1 = '0; req_a1 = '0; req_b1 = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_data", 32'(rsp_data), 32'd0);
        chk("reset op_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);

        // Both requesters valid straight after reset: requester 0 first
        req_op0 = 3'd1; req_a0 = 8'd15; req_b0 = 8'd6;
        req_op1 = 3'd2; req_a1 = 8'hAA; req_b1 = 8'hCC;
        req_valid = 2'b11;
        #1;
        chk("rr first grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rr exec ready low", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rr rsp0 data", 32'(rsp_data), 32'd9);
        chk("rr rsp0 id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        #1;
        chk("rr no accept on complete", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_count++;
        @(negedge clk);
        chk("rr second grant", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("rr rsp1 valid", 32'(rsp_valid), 32'd1);
        chk("rr rsp1 data", 32'(rsp_data), 32'h88);
        chk("rr rsp1 id", 32'(rsp_id), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_count++;
        chk("rr op_count", 32'(op_count), 32'(exp_count));

        // Table of single-requester operations, alternating requesters
        for (int i = 0; i < 10; i++) begin
            run_op(1'(i % 2), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Backpressure: response held for 5 cycles while both requesters wait
        req_op0 = 3'd0; req_a0 = 8'd3; req_b0 = 8'd4;
        req_valid = 2'b01;
        @(negedge clk);
        chk("bp accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b11;
        req_op0 = 3'd3; req_a0 = 8'h55; req_b0 = 8'h00;
        @(negedge clk);
        @(negedge clk);
        hold_data = 8'd7;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d data", k), 32'(rsp_data), 32'(hold_data));
            chk($sformatf("bp%0d id", k), 32'(rsp_id), 32'd0);
            chk($sformatf("bp%0d err", k), 32'(rsp_err), 32'd0);
            chk($sformatf("bp%0d busy", k), 32'(busy), 32'd1);
            chk($sformatf("bp%0d ready", k), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d count", k), 32'(op_count), 32'(exp_count));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        exp_count++;
        chk("bp count once", 32'(op_count), 32'(exp_count));
        @(negedge clk);
        chk("bp count stays", 32'(op_count), 32'(exp_count));

        // Request withdrawn before any edge leaves no trace
        req_valid = 2'b10;
        #2;
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk("drop busy", 32'(busy), 32'd0);

        // Reset pulse during EXEC aborts the operation
        req_op1 = 3'd0; req_a1 = 8'd1; req_b1 = 8'd1;
        req_valid = 2'b10;
        @(negedge clk);
        chk("abort accept", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("abort in exec", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort op_count", 32'(op_count), 32'd0);
        #1 rst_n = 1'b1;
        exp_count = 0;
        repeat (3) begin
            @(negedge clk);
            chk("abort no rsp", 32'(rsp_valid), 32'd0);
        end
        chk("abort count", 32'(op_count), 32'd0);
        req_op0 = 3'd0; req_a0 = 8'd2; req_b0 = 8'd2;
        req_op1 = 3'd0; req_a1 = 8'd9; req_b1 = 8'd9;
        req_valid = 2'b11;
        #1;
        chk("post reset grant", 32'(req_ready), 32'd1);
        req_valid = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
